systolic_row_sequencer: RTL

SYSTOLIC_ROW_SEQUENCER -- requirements
Module: systolic_row_sequencer

---
 rtl/systolic_row_sequencer_if.sv | 29 ++
 rtl/systolic_row_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/systolic_row_sequencer_if.sv
// systolic_row_sequencer_if: host, PE-row and result handshake bundle for the row sequencer
interface systolic_row_sequencer_if #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int ROW_W = 8
);
  logic start;
  logic abort;
  logic [ROW_W-1:0] num_rows;
  logic pe_wr_en;
  logic pe_start;
  logic chain_done;
  logic [OUTPUT_WIDTH-1:0] chain_partial;
  logic [ROW_W-1:0] row_addr;
  logic result_valid;
  logic result_ready;
  logic [OUTPUT_WIDTH-1:0] result_data;
  logic [ROW_W-1:0] result_row;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, abort, num_rows, chain_done, chain_partial, result_ready,
    input pe_wr_en, pe_start, row_addr, result_valid, result_data, result_row, busy, done, err
  );
  modport slave (
    input start, abort, num_rows, chain_done, chain_partial, result_ready,
    output pe_wr_en, pe_start, row_addr, result_valid, result_data, result_row, busy, done, err
  );
endinterface

// File: rtl/systolic_row_sequencer.sv
// systolic_row_sequencer: steps a chained PE row through LOAD/FIRE/WAIT/OUT per row; define SEQ_TIMEOUT_EN for the WAIT watchdog and ERR state
module systolic_row_sequencer #(
  parameter int NUM_PE = 4,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ROW_W = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  systolic_row_sequencer_if.slave bus
);
`ifdef SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_OUT, S_DONE, S_ERR} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_OUT, S_DONE} state_t;
  assign bus.err = 1'b0;
`endif
  state_t state;
  logic [ROW_W-1:0] rows;
  logic [OUTPUT_WIDTH-1:0] partial;
  assign partial = bus.chain_partial;
  if (NUM_PE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("NUM_PE and TIMEOUT_CYCLES must be at least 1");
  end
  // Sequencer FSM; every output is written alongside the state it belongs to, so all outputs are registered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      rows <= '0;
      bus.pe_wr_en <= 1'b0;
      bus.pe_start <= 1'b0;
      bus.row_addr <= '0;
      bus.result_valid <= 1'b0;
      bus.result_data <= '0;
      bus.result_row <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      bus.err <= 1'b0;
      cnt <= '0;
`endif
    end else if (bus.abort && state != S_IDLE) begin
      state <= S_IDLE;
      bus.pe_wr_en <= 1'b0;
      bus.pe_start <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.start) begin
`ifdef SEQ_TIMEOUT_EN
            bus.err <= 1'b0;
`endif
            if (bus.num_rows != '0) begin
              rows <= bus.num_rows;
              bus.row_addr <= '0;
              bus.busy <= 1'b1;
              state <= S_LOAD;
            end else begin
              bus.done <= 1'b1;
              state <= S_DONE;
            end
          end
        S_LOAD: begin
          bus.pe_wr_en <= 1'b1;
          bus.pe_start <= 1'b1;
          state <= S_FIRE;
        end
        S_FIRE: begin
          bus.pe_start <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT:
          if (bus.chain_done) begin
            bus.result_data <= partial;
            bus.result_row <= bus.row_addr;
            bus.pe_wr_en <= 1'b0;
            bus.result_valid <= 1'b1;
            state <= S_OUT;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            bus.pe_wr_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.err <= 1'b1;
            bus.done <= 1'b1;
            state <= S_ERR;
          end else
            cnt <= cnt + 1'b1;
`endif
        S_OUT:
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            if (bus.row_addr == rows - 1'b1) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state <= S_DONE;
            end else begin
              bus.row_addr <= bus.row_addr + 1'b1;
              state <= S_LOAD;
            end
          end
        default: begin
          bus.done <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
endmodule
